// File: rtl/vpu_pkg.sv
// Shared types and sizing for the vector processing unit.
package vpu_pkg;

  localparam int SRAM_R_PORT_CNT = 3;
  localparam int OPERAND_WIDTH   = 16;
  localparam int LANE_CNT        = 32;
  localparam int SRAM_DATA_WIDTH = LANE_CNT * OPERAND_WIDTH;
  localparam int ADDR_WIDTH      = 10;

  typedef enum logic [4:0] {
    UIADD  = 5'd1,
    UIADD3 = 5'd2,
    UIMUL  = 5'd3,
    UISUM  = 5'd4,
    FMAX   = 5'd17
  } vpu_h2d_req_opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_EXEC,
    ST_WR
  } vpu_state_t;

endpackage

// File: rtl/vpu_alu_lane.sv
// One 16-bit lane of the VPU datapath: integer add/add3/mul and bf16 max.
module vpu_alu_lane
  import vpu_pkg::*;
(
  input  logic [4:0]               op_i,
  input  logic [OPERAND_WIDTH-1:0] a_i,
  input  logic [OPERAND_WIDTH-1:0] b_i,
  input  logic [OPERAND_WIDTH-1:0] c_i,
  output logic [OPERAND_WIDTH-1:0] y_o
);

  logic                     a_nan;
  logic                     b_nan;
  logic                     both_zero;
  logic                     a_gt_b;
  logic [OPERAND_WIDTH-1:0] fmax;

  // Sign-magnitude ordering: magnitudes compare as unsigned, reversed when both negative.
  always_comb begin
    a_nan     = (a_i[14:7] == 8'hFF) && (a_i[6:0] != 7'd0);
    b_nan     = (b_i[14:7] == 8'hFF) && (b_i[6:0] != 7'd0);
    both_zero = (a_i[14:0] == 15'd0) && (b_i[14:0] == 15'd0);
    if (a_i[15] != b_i[15]) begin
      a_gt_b = !a_i[15];
    end else if (!a_i[15]) begin
      a_gt_b = a_i[14:0] > b_i[14:0];
    end else begin
      a_gt_b = a_i[14:0] < b_i[14:0];
    end
    if (a_nan || b_nan) begin
      fmax = 16'h7FC0;
    end else if (both_zero) begin
      fmax = 16'h0000;
    end else begin
      fmax = a_gt_b ? a_i : b_i;
    end
  end

  always_comb begin
    y_o = '0;
    case (op_i)
      UIADD:   y_o = a_i + b_i;
      UIADD3:  y_o = a_i + b_i + c_i;
      UIMUL:   y_o = a_i * b_i;
      FMAX:    y_o = fmax;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/vpu_top.sv
// Vector processing unit: reads three 512-bit source vectors, computes a lane-wise
// or reduction result and writes one vector back; one operation in flight at a time.
module vpu_top
  import vpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [4:0]              req_opcode_i,
  input  logic [3*ADDR_WIDTH-1:0] req_src_addr_i,
  input  logic [ADDR_WIDTH-1:0]   req_dst_addr_i,
  output logic                    src0_rden_o,
  output logic [ADDR_WIDTH-1:0]   src0_raddr_o,
  input  logic                    src0_rvalid_i,
  input  logic [511:0]            src0_rdata_i,
  output logic                    src1_rden_o,
  output logic [ADDR_WIDTH-1:0]   src1_raddr_o,
  input  logic                    src1_rvalid_i,
  input  logic [511:0]            src1_rdata_i,
  output logic                    src2_rden_o,
  output logic [ADDR_WIDTH-1:0]   src2_raddr_o,
  input  logic                    src2_rvalid_i,
  input  logic [511:0]            src2_rdata_i,
  output logic                    dst_wren_o,
  output logic [ADDR_WIDTH-1:0]   dst_waddr_o,
  output logic [511:0]            dst_wdata_o,
  input  logic                    dst_wready_i
);

  vpu_state_t                                      state_q, state_d;
  logic [4:0]                                      opcode_q, opcode_d;
  logic [3*ADDR_WIDTH-1:0]                         src_addr_q, src_addr_d;
  logic [ADDR_WIDTH-1:0]                           dst_addr_q, dst_addr_d;
  logic [SRAM_R_PORT_CNT-1:0]                      captured_q, captured_d;
  logic [SRAM_R_PORT_CNT-1:0][SRAM_DATA_WIDTH-1:0] src_data_q, src_data_d;
  logic [SRAM_DATA_WIDTH-1:0]                      wdata_q, wdata_d;

  logic [SRAM_R_PORT_CNT-1:0]                      rvalid;
  logic [SRAM_R_PORT_CNT-1:0][SRAM_DATA_WIDTH-1:0] rdata;
  logic [LANE_CNT-1:0][OPERAND_WIDTH-1:0]          lane_y;
  logic [OPERAND_WIDTH-1:0]                        uisum;
  logic [SRAM_DATA_WIDTH-1:0]                      result;

  assign rvalid = {src2_rvalid_i, src1_rvalid_i, src0_rvalid_i};
  assign rdata  = {src2_rdata_i, src1_rdata_i, src0_rdata_i};

  for (genvar k = 0; k < LANE_CNT; k++) begin : g_lane
    vpu_alu_lane u_lane (
      .op_i (opcode_q),
      .a_i  (src_data_q[0][k*OPERAND_WIDTH +: OPERAND_WIDTH]),
      .b_i  (src_data_q[1][k*OPERAND_WIDTH +: OPERAND_WIDTH]),
      .c_i  (src_data_q[2][k*OPERAND_WIDTH +: OPERAND_WIDTH]),
      .y_o  (lane_y[k])
    );
  end

  always_comb begin
    uisum = '0;
    for (int k = 0; k < LANE_CNT; k++) begin
      uisum = uisum + src_data_q[0][k*OPERAND_WIDTH +: OPERAND_WIDTH];
    end
    if (opcode_q == UISUM) begin
      result = '0;
      result[OPERAND_WIDTH-1:0] = uisum;
    end else begin
      result = lane_y;
    end
  end

  // Each port is captured once on its own rvalid; later strobes for that port are ignored.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    captured_d = captured_q;
    src_data_d = src_data_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          opcode_d   = req_opcode_i;
          src_addr_d = req_src_addr_i;
          dst_addr_d = req_dst_addr_i;
          captured_d = '0;
          state_d    = ST_RD_REQ;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        for (int p = 0; p < SRAM_R_PORT_CNT; p++) begin
          if (rvalid[p] && !captured_q[p]) begin
            captured_d[p] = 1'b1;
            src_data_d[p] = rdata[p];
          end
        end
        if (&captured_d) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        wdata_d = result;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (dst_wready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      captured_q <= '0;
      src_data_q <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      captured_q <= captured_d;
      src_data_q <= src_data_d;
      wdata_q    <= wdata_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign src0_rden_o  = (state_q == ST_RD_REQ);
  assign src1_rden_o  = (state_q == ST_RD_REQ);
  assign src2_rden_o  = (state_q == ST_RD_REQ);
  assign src0_raddr_o = src_addr_q[0*ADDR_WIDTH +: ADDR_WIDTH];
  assign src1_raddr_o = src_addr_q[1*ADDR_WIDTH +: ADDR_WIDTH];
  assign src2_raddr_o = src_addr_q[2*ADDR_WIDTH +: ADDR_WIDTH];
  assign dst_wren_o   = (state_q == ST_WR);
  assign dst_waddr_o  = dst_addr_q;
  assign dst_wdata_o  = wdata_q;

endmodule

// File: tb/tb_vpu_top.sv
// Scoreboard bench for vpu_top: requests push expected writes, a negedge monitor pops and
// compares on every write handshake; a behavioural SRAM returns operands with variable latency.
module tb_vpu_top;

  typedef struct packed {
    logic [9:0]   addr;
    logic [511:0] data;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [4:0]   req_opcode;
  logic [29:0]  req_src_addr;
  logic [9:0]   req_dst_addr;
  logic [2:0]   rden;
  logic [9:0]   raddr [3];
  logic [2:0]   resp_valid;
  logic [511:0] resp_data [3];
  logic         stray_valid;
  logic         dst_wren;
  logic [9:0]   dst_waddr;
  logic [511:0] dst_wdata;
  logic         dst_wready;

  exp_t         exp_q[$];
  logic [511:0] cur_vec [3];
  logic [29:0]  cur_src;
  int           delay_mode;
  int           checks;
  int           errors;
  int           issued_count;
  int           aborted_count;
  int           write_count;

  vpu_top dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_opcode_i   (req_opcode),
    .req_src_addr_i (req_src_addr),
    .req_dst_addr_i (req_dst_addr),
    .src0_rden_o    (rden[0]),
    .src0_raddr_o   (raddr[0]),
    .src0_rvalid_i  (resp_valid[0] | stray_valid),
    .src0_rdata_i   (resp_data[0]),
    .src1_rden_o    (rden[1]),
    .src1_raddr_o   (raddr[1]),
    .src1_rvalid_i  (resp_valid[1] | stray_valid),
    .src1_rdata_i   (resp_data[1]),
    .src2_rden_o    (rden[2]),
    .src2_raddr_o   (raddr[2]),
    .src2_rvalid_i  (resp_valid[2] | stray_valid),
    .src2_rdata_i   (resp_data[2]),
    .dst_wren_o     (dst_wren),
    .dst_waddr_o    (dst_waddr),
    .dst_wdata_o    (dst_wdata),
    .dst_wready_i   (dst_wready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] rep16(input logic [15:0] x);
    logic [511:0] v;
    for (int k = 0; k < 32; k++) v[16*k +: 16] = x;
    return v;
  endfunction

  // Numeric value of a bf16 pattern; infinities map to a huge real.
  function automatic real bf_val(input logic [15:0] x);
    int  e;
    real m;
    real v;
    e = int'(x[14:7]);
    m = real'(x[6:0]);
    if (e == 255)    v = 1.0e300;
    else if (e == 0) v = (m / 128.0) * (2.0 ** (-126.0));
    else             v = (1.0 + m / 128.0) * (2.0 ** (real'(e) - 127.0));
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] fmax_model(input logic [15:0] a, input logic [15:0] b);
    real va;
    real vb;
    if ((a[14:7] == 8'hFF && a[6:0] != 0) || (b[14:7] == 8'hFF && b[6:0] != 0)) return 16'h7FC0;
    va = bf_val(a);
    vb = bf_val(b);
    if (va > vb) return a;
    if (vb > va) return b;
    if (va == 0.0) return 16'h0000;
    return a;
  endfunction

  function automatic logic [511:0] model(input int op, input logic [511:0] a,
                                         input logic [511:0] b, input logic [511:0] c);
    logic [511:0] r;
    longint       s;
    r = '0;
    s = 0;
    for (int k = 0; k < 32; k++) begin
      longint x, y, z;
      x = longint'(a[16*k +: 16]);
      y = longint'(b[16*k +: 16]);
      z = longint'(c[16*k +: 16]);
      s += x;
      case (op)
        1:       r[16*k +: 16] = 16'((x + y) % 65536);
        2:       r[16*k +: 16] = 16'((x + y + z) % 65536);
        3:       r[16*k +: 16] = 16'((x * y) % 65536);
        17:      r[16*k +: 16] = fmax_model(a[16*k +: 16], b[16*k +: 16]);
        default: ;
      endcase
    end
    if (op == 4) r[15:0] = 16'(s % 65536);
    return r;
  endfunction

  function automatic logic [511:0] fmax_vec();
    logic [15:0]  sp [8];
    logic [511:0] v;
    sp = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC1, 16'h0001, 16'h8001, 16'h3F80};
    v = rand_vec();
    for (int k = 0; k < 32; k++) begin
      if ($urandom_range(0, 3) == 0) v[16*k +: 16] = sp[$urandom_range(0, 7)];
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic [4:0] op, input logic [9:0] dst, input logic [511:0] a,
                               input logic [511:0] b, input logic [511:0] c, input logic [511:0] exp_v);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("req_accept_timeout", 512'(req_ready), 512'd1);
      return;
    end
    cur_vec[0] = a;
    cur_vec[1] = b;
    cur_vec[2] = c;
    cur_src    = 30'($urandom);
    e.addr     = dst;
    e.data     = exp_v;
    exp_q.push_back(e);
    req_valid    = 1'b1;
    req_opcode   = op;
    req_src_addr = cur_src;
    req_dst_addr = dst;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_opcode   = 5'($urandom);
    issued_count++;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 512'(exp_q.size()), 512'd0);
  endtask

  task automatic randomRequest();
    int           op;
    logic [511:0] a, b, c;
    case ($urandom_range(0, 5))
      0: op = 1;
      1: op = 2;
      2: op = 3;
      3: op = 4;
      4: op = 17;
      default: begin
        op = int'($urandom_range(0, 31));
        while (op == 1 || op == 2 || op == 3 || op == 4 || op == 17) op = int'($urandom_range(0, 31));
      end
    endcase
    a = (op == 17) ? fmax_vec() : rand_vec();
    b = (op == 17) ? fmax_vec() : rand_vec();
    c = rand_vec();
    applyStimulus(5'(op), 10'($urandom), a, b, c, model(op, a, b, c));
  endtask

  // Behavioural SRAM: each port answers its read strobe after 1, 1..5 or 5 cycles.
  initial begin
    int cnt [3];
    for (int p = 0; p < 3; p++) begin
      cnt[p]        = 0;
      resp_valid[p] = 1'b0;
      resp_data[p]  = '0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        if (rden[p] && cnt[p] == 0) begin
          cnt[p] = (delay_mode == 0) ? 1 : (delay_mode == 2) ? 5 : int'($urandom_range(1, 5));
          checkOutput($sformatf("raddr%0d", p), 512'(raddr[p]), 512'(cur_src[10*p +: 10]));
        end
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 3; p++) begin
        resp_valid[p] = 1'b0;
        resp_data[p]  = rand_vec();
        if (cnt[p] > 0) begin
          cnt[p]--;
          if (cnt[p] == 0) begin
            resp_valid[p] = 1'b1;
            resp_data[p]  = cur_vec[p];
          end
        end
      end
    end
  end

  // Monitor: pop the scoreboard on each write handshake, otherwise require ready low while busy.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dst_wren && dst_wready) begin
      write_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 512'd1, 512'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 512'(dst_waddr), 512'(e.addr));
        checkOutput("wr_data", dst_wdata, e.data);
      end
    end else if (rst_n && issued_count > write_count + aborted_count) begin
      checkOutput("ready_busy", 512'(req_ready), 512'd0);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [511:0] a, b, c, e;
    int           n;
    int           wc0;
    logic [15:0]  fa [4];
    logic [15:0]  fb [4];
    logic [15:0]  fy [4];

    checks = 0; errors = 0; issued_count = 0; aborted_count = 0; write_count = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_src_addr = '0; req_dst_addr = '0;
    dst_wready = 1'b1; stray_valid = 1'b0; delay_mode = 0; cur_src = '0;
    for (int p = 0; p < 3; p++) cur_vec[p] = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_rden", 512'(rden), 512'd0);
    checkOutput("rst_wren", 512'(dst_wren), 512'd0);
    checkOutput("rst_waddr", 512'(dst_waddr), 512'd0);
    checkOutput("rst_wdata", dst_wdata, 512'd0);
    checkOutput("rst_raddr", 512'({raddr[2], raddr[1], raddr[0]}), 512'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 512'(req_ready), 512'd1);

    $display("[TB] directed operations");
    applyStimulus(5'd1, 10'h011, rep16(16'hFFFF), rep16(16'h0002), rand_vec(), rep16(16'h0001));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dst_wren && n < 20);
    checkOutput("latency", 512'(n), 512'd4);

    applyStimulus(5'd2, 10'h022, rep16(16'd1), rep16(16'd2), rep16(16'd3), rep16(16'h0006));
    for (int k = 0; k < 32; k++) begin
      a[16*k +: 16] = k[0] ? 16'h00FF : 16'h0100;
      b[16*k +: 16] = k[0] ? 16'h0003 : 16'h0100;
      e[16*k +: 16] = k[0] ? 16'h02FD : 16'h0000;
    end
    applyStimulus(5'd3, 10'h033, a, b, rand_vec(), e);
    e = '0;
    e[15:0] = 16'h0080;
    applyStimulus(5'd4, 10'h044, rep16(16'd4), rand_vec(), rand_vec(), e);
    applyStimulus(5'd9, 10'h099, rand_vec(), rand_vec(), rand_vec(), '0);
    fa = '{16'h3F80, 16'hBF80, 16'h0000, 16'h7FC1};
    fb = '{16'hC000, 16'hC000, 16'h8000, 16'h3F80};
    fy = '{16'h3F80, 16'hBF80, 16'h0000, 16'h7FC0};
    for (int k = 0; k < 32; k++) begin
      a[16*k +: 16] = fa[k % 4];
      b[16*k +: 16] = fb[k % 4];
      e[16*k +: 16] = fy[k % 4];
    end
    applyStimulus(5'd17, 10'h117, a, b, rand_vec(), e);
    waitDrain();

    $display("[TB] back-to-back FMAX with random read latency");
    delay_mode = 1;
    wc0 = write_count;
    for (int i = 0; i < 7; i++) begin
      a = fmax_vec();
      b = fmax_vec();
      c = rand_vec();
      applyStimulus(5'd17, 10'(10'h200 + i), a, b, c, model(17, a, b, c));
    end
    waitDrain();
    checkOutput("b2b_writes", 512'(write_count - wc0), 512'd7);

    $display("[TB] write backpressure");
    delay_mode = 0;
    dst_wready = 1'b0;
    wc0 = write_count;
    a = rand_vec();
    b = rand_vec();
    c = rand_vec();
    e = model(1, a, b, c);
    applyStimulus(5'd1, 10'h155, a, b, c, e);
    n = 0;
    while (!dst_wren && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_wren", 512'(dst_wren), 512'd1);
      checkOutput("stall_waddr", 512'(dst_waddr), 512'h155);
      checkOutput("stall_wdata", dst_wdata, e);
      @(negedge clk);
    end
    dst_wready = 1'b1;
    waitDrain();
    repeat (3) @(negedge clk);
    checkOutput("stall_writes", 512'(write_count - wc0), 512'd1);

    $display("[TB] reset abort during read wait");
    delay_mode = 2;
    wc0 = write_count;
    applyStimulus(5'd3, 10'h3AA, rand_vec(), rand_vec(), rand_vec(), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    aborted_count++;
    void'(exp_q.pop_back());
    @(negedge clk);
    checkOutput("abort_ready", 512'(req_ready), 512'd1);
    checkOutput("abort_wren", 512'(dst_wren), 512'd0);
    repeat (10) @(negedge clk);
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_ready_after_stray", 512'(req_ready), 512'd1);
    checkOutput("abort_no_write", 512'(write_count - wc0), 512'd0);
    delay_mode = 1;
    a = rand_vec();
    b = rand_vec();
    c = rand_vec();
    applyStimulus(5'd2, 10'h3AB, a, b, c, model(2, a, b, c));
    waitDrain();

    $display("[TB] random requests");
    for (int i = 0; i < 25; i++) randomRequest();
    waitDrain();
    repeat (3) @(negedge clk);
    checkOutput("total_writes", 512'(write_count), 512'(issued_count - aborted_count));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
